zbus_chain: RTL and testbench

Parametrised, clocked ZX-bus IORQ daisy-chain manager for NCH external slots. It replaces the fixed two-slot combinational IORQ/IORQGE chain.
- Synchronises the Z80 strobes.
- Walks the IORQ grant down the slot chain stage by stage.
- Records which slot claimed the cycle.
- Drives the free-bus 0xFF enable.
- Detects hung I/O cycles.
It sits between the Z80 bus front-end and the ZX-bus connector drivers.

---
 rtl/zbus_pkg.sv | 21 ++
 rtl/zbus_sync.sv | 27 ++
 rtl/zbus_chain.sv | 153 +++++++++++++++
 tb/tb_zbus_chain.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/zbus_pkg.sv
// Shared definitions for the ZX-bus IORQ daisy-chain manager.
package zbus_pkg;

   localparam int unsigned SyncDepth = 2;

   typedef enum logic [2:0] {
      StIdle,
      StChain,
      StOwned,
      StFree,
      StInternal,
      StInta,
      StAbort
   } state_e;

   // Owner index reported when no slot has claimed the cycle.
   function automatic int unsigned owner_none(input int unsigned nch);
      return nch;
   endfunction

endpackage

// File: rtl/zbus_sync.sv
// N-bit multi-flop synchroniser with a configurable reset value.
module zbus_sync
   import zbus_pkg::*;
#(
   parameter int unsigned           Width    = 1,
   parameter logic [Width-1:0]      ResetVal = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [Width-1:0] d,
   output logic [Width-1:0] q
);

   logic [Width-1:0] stg_q [SyncDepth];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SyncDepth; i++) stg_q[i] <= ResetVal;
      end else begin
         stg_q[0] <= d;
         for (int i = 1; i < SyncDepth; i++) stg_q[i] <= stg_q[i-1];
      end
   end

   assign q = stg_q[SyncDepth-1];

endmodule

// File: rtl/zbus_chain.sv
// Clocked ZX-bus IORQ daisy chain: grants IORQ slot by slot, tracks the claiming
// slot, drives the 0xFF free-bus enable and aborts hung I/O cycles.
module zbus_chain
   import zbus_pkg::*;
#(
   parameter int unsigned NCH    = 2,
   parameter int unsigned SETTLE = 2,
   parameter int unsigned TMO    = 255,
   parameter int unsigned OW     = $clog2(NCH+1)
) (
   input  logic           fclk,
   input  logic           rst_n,
   input  logic           iorq_n,
   input  logic           rd_n,
   input  logic           m1_n,
   input  logic           porthit,
   input  logic [NCH-1:0] slot_en,
   input  logic [NCH-1:0] iorqge,
   input  logic           tmo_clr,
   output logic [NCH-1:0] slot_iorq_n,
   output logic           drive_ff,
   output logic [OW-1:0]  owner,
   output logic           owner_vld,
   output logic           busy,
   output logic           tmo_flag
);

   localparam int unsigned    SW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int unsigned    CW        = $clog2(TMO+1);
   localparam logic [OW-1:0]  OwnerNone = OW'(owner_none(NCH));

   logic [2:0]     strb_s;
   logic           iorq_s, rd_s, m1_s;
   logic [NCH-1:0] ge_s;

   zbus_sync #(.Width(3), .ResetVal(3'b111)) u_sync_strb (
      .clk   (fclk),
      .rst_n (rst_n),
      .d     ({iorq_n, rd_n, m1_n}),
      .q     (strb_s)
   );

   zbus_sync #(.Width(NCH), .ResetVal('0)) u_sync_ge (
      .clk   (fclk),
      .rst_n (rst_n),
      .d     (iorqge),
      .q     (ge_s)
   );

   assign iorq_s = strb_s[2];
   assign rd_s   = strb_s[1];
   assign m1_s   = strb_s[0];

   state_e         state;
   logic [OW-1:0]  stage;
   logic [NCH-1:0] en_q;
   logic [SW-1:0]  scnt;
   logic [CW-1:0]  cyc;
   logic [OW-1:0]  first_k, next_k;
   logic           ge_sel;

   // Lowest enabled slot overall, and lowest latched-enabled slot above the current stage.
   always_comb begin
      first_k = OwnerNone;
      next_k  = OwnerNone;
      for (int i = int'(NCH) - 1; i >= 0; i--) begin
         if (slot_en[i]) first_k = OW'(i);
         if (en_q[i] && (OW'(i) > stage)) next_k = OW'(i);
      end
   end

   assign ge_sel = |(ge_s & (NCH'(1) << stage));
   assign busy   = (state != StIdle);

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= StIdle;
         stage       <= OwnerNone;
         en_q        <= '0;
         scnt        <= '0;
         cyc         <= '0;
         slot_iorq_n <= '1;
         drive_ff    <= 1'b0;
         owner       <= OwnerNone;
         owner_vld   <= 1'b0;
         tmo_flag    <= 1'b0;
      end else begin
         // A timeout set further down overrides this clear.
         if (tmo_clr) tmo_flag <= 1'b0;
         unique case (state)
            StIdle: begin
               if (!iorq_s) begin
                  cyc   <= '0;
                  scnt  <= '0;
                  owner <= OwnerNone;
                  en_q  <= slot_en;
                  if (!m1_s) begin
                     state    <= StInta;
                     drive_ff <= 1'b1;
                  end else if (porthit) begin
                     state <= StInternal;
                  end else if (first_k == OwnerNone) begin
                     state    <= StFree;
                     drive_ff <= ~rd_s;
                  end else begin
                     state       <= StChain;
                     stage       <= first_k;
                     slot_iorq_n <= ~(NCH'(1) << first_k);
                  end
               end
            end
            StAbort: begin
               if (iorq_s) state <= StIdle;
            end
            default: begin
               if (iorq_s) begin
                  state       <= StIdle;
                  slot_iorq_n <= '1;
                  drive_ff    <= 1'b0;
                  owner_vld   <= 1'b0;
               end else if (cyc == CW'(TMO - 1)) begin
                  state       <= StAbort;
                  cyc         <= CW'(TMO);
                  slot_iorq_n <= '1;
                  drive_ff    <= 1'b0;
                  owner_vld   <= 1'b0;
                  tmo_flag    <= 1'b1;
               end else begin
                  cyc <= cyc + CW'(1);
                  if (state == StChain) begin
                     if (scnt != SW'(SETTLE - 1)) begin
                        scnt <= scnt + SW'(1);
                     end else if (ge_sel) begin
                        state     <= StOwned;
                        owner     <= stage;
                        owner_vld <= 1'b1;
                     end else if (next_k == OwnerNone) begin
                        state    <= StFree;
                        drive_ff <= ~rd_s;
                     end else begin
                        stage       <= next_k;
                        scnt        <= '0;
                        slot_iorq_n <= slot_iorq_n & ~(NCH'(1) << next_k);
                     end
                  end
                  if (state == StFree) drive_ff <= ~rd_s;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zbus_chain.sv
// Scoreboard bench for zbus_chain (NCH=3, SETTLE=2, TMO=16).
module tb_zbus_chain;

   logic       fclk = 1'b0;
   logic       rst_n, iorq_n, rd_n, m1_n, porthit, tmo_clr;
   logic [2:0] slot_en, iorqge;
   logic [2:0] slot_iorq_n;
   logic       drive_ff, owner_vld, busy, tmo_flag;
   logic [1:0] owner;

   int n_run  = 0;
   int n_fail = 0;
   int ecnt   = 0;

   typedef struct {
      string      tag;
      int         edge_no;
      logic [2:0] slots;
      logic       drv;
      logic [1:0] own;
      logic       vld;
      logic       bsy;
      logic       tmo;
   } exp_t;

   exp_t sb_q[$];

   zbus_chain #(.NCH(3), .SETTLE(2), .TMO(16)) u_dut (
      .fclk        (fclk),
      .rst_n       (rst_n),
      .iorq_n      (iorq_n),
      .rd_n        (rd_n),
      .m1_n        (m1_n),
      .porthit     (porthit),
      .slot_en     (slot_en),
      .iorqge      (iorqge),
      .tmo_clr     (tmo_clr),
      .slot_iorq_n (slot_iorq_n),
      .drive_ff    (drive_ff),
      .owner       (owner),
      .owner_vld   (owner_vld),
      .busy        (busy),
      .tmo_flag    (tmo_flag)
   );

   always #5 fclk = ~fclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_at(input string tag, input int e, input logic [2:0] s, input logic d,
                            input logic [1:0] o, input logic v, input logic b, input logic t);
      exp_t x;
      x.tag = tag; x.edge_no = e; x.slots = s; x.drv = d;
      x.own = o;   x.vld = v;     x.bsy = b;   x.tmo = t;
      sb_q.push_back(x);
   endtask

   // Advance n edges; after each, compare any scoreboard entries due at that edge.
   task automatic run_edges(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge fclk);
         ecnt++;
         @(negedge fclk);
         while (sb_q.size() > 0 && sb_q[0].edge_no == ecnt) begin
            exp_t x;
            x = sb_q.pop_front();
            check({x.tag, ".slots"}, 32'(slot_iorq_n), 32'(x.slots));
            check({x.tag, ".drive"}, 32'(drive_ff),    32'(x.drv));
            check({x.tag, ".owner"}, 32'(owner),       32'(x.own));
            check({x.tag, ".vld"},   32'(owner_vld),   32'(x.vld));
            check({x.tag, ".busy"},  32'(busy),        32'(x.bsy));
            check({x.tag, ".tmo"},   32'(tmo_flag),    32'(x.tmo));
         end
      end
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   task automatic start_io(input logic rd, input logic m1, input logic hit,
                           input logic [2:0] en, input logic [2:0] ge);
      @(posedge fclk);
      #1;
      rd_n = rd; m1_n = m1; porthit = hit; slot_en = en; iorqge = ge;
      iorq_n = 1'b0;
      ecnt = 0;
   endtask

   task automatic end_io();
      @(posedge fclk);
      #1;
      iorq_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1; porthit = 1'b0; iorqge = 3'b000;
      ecnt = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".slots"}, 32'(slot_iorq_n), 32'h7);
      check({tag, ".drive"}, 32'(drive_ff),    32'h0);
      check({tag, ".owner"}, 32'(owner),       32'h3);
      check({tag, ".vld"},   32'(owner_vld),   32'h0);
      check({tag, ".busy"},  32'(busy),        32'h0);
      check({tag, ".tmo"},   32'(tmo_flag),    32'h0);
   endtask

   // Two enabled slots, nobody claims: grant walks 110 -> 100, then free-bus read.
   task automatic cycle_free_read(input string tag);
      start_io(1'b0, 1'b1, 1'b0, 3'b011, 3'b000);
      expect_at({tag, ".pre"},  2, 3'b111, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
      expect_at({tag, ".s0"},   3, 3'b110, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
      expect_at({tag, ".s1"},   5, 3'b100, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
      expect_at({tag, ".free"}, 7, 3'b100, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
      run_edges(8);
      end_io();
      expect_at({tag, ".hold"}, 2, 3'b100, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
      expect_at({tag, ".idle"}, 3, 3'b111, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
      run_edges(4);
   endtask

   initial begin
      rst_n = 1'b0; iorq_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1; porthit = 1'b0;
      slot_en = 3'b000; iorqge = 3'b000; tmo_clr = 1'b0;
      #12;
      check_reset_outputs("rst");
      @(posedge fclk);
      #1 rst_n = 1'b1;

      cycle_free_read("A");

      // Slot 0 claims at the first stage; slot 1 never granted.
      start_io(1'b0, 1'b1, 1'b0, 3'b011, 3'b001);
      expect_at("B.s0",   3, 3'b110, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
      expect_at("B.own",  5, 3'b110, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
      expect_at("B.hold", 7, 3'b110, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
      run_edges(8);
      end_io();
      expect_at("B.idle", 3, 3'b111, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      run_edges(4);

      // Slot 1 disabled: skipped without stage time, slot 2 claims.
      start_io(1'b0, 1'b1, 1'b0, 3'b101, 3'b100);
      expect_at("C.s0",   3, 3'b110, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
      expect_at("C.s0b",  4, 3'b110, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
      expect_at("C.s2",   5, 3'b010, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
      expect_at("C.own",  7, 3'b010, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0);
      run_edges(8);
      end_io();
      expect_at("C.idle", 3, 3'b111, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
      run_edges(4);

      // Internal port hit: no grant, no drive.
      start_io(1'b0, 1'b1, 1'b1, 3'b011, 3'b011);
      expect_at("D.int",  3, 3'b111, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
      expect_at("D.hold", 6, 3'b111, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
      run_edges(7);
      end_io();
      expect_at("D.idle", 3, 3'b111, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
      run_edges(4);

      // INTA (with porthit also high): drive 0xFF for the whole cycle.
      start_io(1'b1, 1'b0, 1'b1, 3'b011, 3'b000);
      expect_at("E.inta", 3, 3'b111, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
      expect_at("E.hold", 8, 3'b111, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
      run_edges(9);
      end_io();
      expect_at("E.last", 2, 3'b111, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
      expect_at("E.idle", 3, 3'b111, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
      run_edges(4);

      // Hung write cycle: abort 16 edges after leaving idle; set beats a coincident clear.
      start_io(1'b1, 1'b1, 1'b0, 3'b011, 3'b000);
      expect_at("F.s0",   3,  3'b110, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
      expect_at("F.free", 7,  3'b100, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
      expect_at("F.pre",  18, 3'b100, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
      run_edges(18);
      tmo_clr = 1'b1;
      expect_at("F.abort", 19, 3'b111, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1);
      run_edges(1);
      tmo_clr = 1'b0;
      expect_at("F.stuck", 30, 3'b111, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1);
      run_edges(21);
      end_io();
      expect_at("F.idle", 3, 3'b111, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
      run_edges(4);
      @(posedge fclk);
      #1 tmo_clr = 1'b1;
      ecnt = 0;
      expect_at("F.clr", 1, 3'b111, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
      run_edges(1);
      tmo_clr = 1'b0;

      // Asynchronous reset while owned, then a normal chain afterwards.
      start_io(1'b0, 1'b1, 1'b0, 3'b011, 3'b001);
      expect_at("G.own", 5, 3'b110, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
      run_edges(6);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("G.rst");
      iorq_n = 1'b1; rd_n = 1'b1; iorqge = 3'b000;
      @(posedge fclk);
      #1 rst_n = 1'b1;
      run_edges(3);
      cycle_free_read("H");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
